// File: rtl/sd_pkg.sv
// Signed-digit (borrow-save, radix-2) shared types, encodings and helpers.
package sd_pkg;

    localparam int unsigned DW = 4;
    localparam int unsigned MW = 3;

    typedef logic [1:0] sd_digit_t;

    localparam sd_digit_t SD_POS  = 2'b10;
    localparam sd_digit_t SD_NEG  = 2'b01;
    localparam sd_digit_t SD_ZERO = 2'b00;

    // 11 decodes to zero, same as 00.
    function automatic logic signed [2:0] sd_val(input sd_digit_t d);
        case (d)
            SD_POS:  return 3'sb001;
            SD_NEG:  return 3'sb111;
            default: return 3'sb000;
        endcase
    endfunction

    function automatic sd_digit_t sd_enc(input logic signed [2:0] v);
        if (v > 3'sb000)
            return SD_POS;
        else if (v < 3'sb000)
            return SD_NEG;
        else
            return SD_ZERO;
    endfunction

endpackage

// File: rtl/sd_add4.sv
// Four-digit carry-limited signed-digit adder: s + 16*cout = a + b + cin.
module sd_add4
    import sd_pkg::*;
(
    input  logic [DW-1:0] a_plus,
    input  logic [DW-1:0] a_minus,
    input  logic [DW-1:0] b_plus,
    input  logic [DW-1:0] b_minus,
    input  sd_digit_t     cin,
    output logic [DW-1:0] s_plus,
    output logic [DW-1:0] s_minus,
    output sd_digit_t     cout
);

    logic signed [2:0] pos_sum;
    logic signed [2:0] t_cur;
    logic signed [2:0] w_cur;
    logic signed [2:0] t_prev;
    logic signed [2:0] s_val;
    logic              prev_nonneg;
    sd_digit_t         s_dig;

    // t_i is chosen from p_{i-1}'s sign so w_i + t_{i-1} never leaves -1..1.
    always_comb begin
        s_plus      = '0;
        s_minus     = '0;
        pos_sum     = 3'sb000;
        t_cur       = 3'sb000;
        w_cur       = 3'sb000;
        s_val       = 3'sb000;
        s_dig       = SD_ZERO;
        t_prev      = sd_val(cin);
        prev_nonneg = (sd_val(cin) >= 3'sb000);
        for (int i = 0; i < int'(DW); i++) begin
            pos_sum = sd_val({a_plus[i], a_minus[i]}) + sd_val({b_plus[i], b_minus[i]});
            case (pos_sum)
                3'sb010: begin t_cur = 3'sb001; w_cur = 3'sb000; end
                3'sb110: begin t_cur = 3'sb111; w_cur = 3'sb000; end
                3'sb001: begin
                    t_cur = prev_nonneg ? 3'sb001 : 3'sb000;
                    w_cur = prev_nonneg ? 3'sb111 : 3'sb001;
                end
                3'sb111: begin
                    t_cur = prev_nonneg ? 3'sb000 : 3'sb111;
                    w_cur = prev_nonneg ? 3'sb111 : 3'sb001;
                end
                default: begin t_cur = 3'sb000; w_cur = 3'sb000; end
            endcase
            s_val      = w_cur + t_prev;
            s_dig      = sd_enc(s_val);
            s_plus[i]  = s_dig[1];
            s_minus[i] = s_dig[0];
            t_prev      = t_cur;
            prev_nonneg = (pos_sum >= 3'sb000);
        end
        cout = sd_enc(t_prev);
    end

endmodule

// File: rtl/sd_adder_slice.sv
// Borrow-save arithmetic slice: two cascaded sd_add4 stages, carry registers, M-block.
module sd_adder_slice
    import sd_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_adder,
    input  logic          carry_clr,
    input  logic [DW-1:0] x_plus,
    input  logic [DW-1:0] x_minus,
    input  logic [DW-1:0] y_plus,
    input  logic [DW-1:0] y_minus,
    input  logic [DW-1:0] residue_plus,
    input  logic [DW-1:0] residue_minus,
    output logic [DW-1:0] z_plus,
    output logic [DW-1:0] z_minus,
    output logic [DW-1:0] tmp_plus,
    output logic [DW-1:0] tmp_minus,
    output sd_digit_t     cout_one,
    output sd_digit_t     cout_two,
    output sd_digit_t     cin_one,
    output sd_digit_t     cin_two,
    input  logic [DW-1:0] v_plus,
    input  logic [DW-1:0] v_minus,
    input  sd_digit_t     p,
    output logic [MW-1:0] w_upper_plus,
    output logic [MW-1:0] w_upper_minus,
    output logic          m_ovf
);

    sd_add4 u_stage1 (
        .a_plus  (x_plus),
        .a_minus (x_minus),
        .b_plus  (y_plus),
        .b_minus (y_minus),
        .cin     (cin_one),
        .s_plus  (z_plus),
        .s_minus (z_minus),
        .cout    (cout_one)
    );

    sd_add4 u_stage2 (
        .a_plus  (z_plus),
        .a_minus (z_minus),
        .b_plus  (residue_plus),
        .b_minus (residue_minus),
        .cin     (cin_two),
        .s_plus  (tmp_plus),
        .s_minus (tmp_minus),
        .cout    (cout_two)
    );

    // Inter-slice carries; clear has priority over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin_one <= SD_ZERO;
            cin_two <= SD_ZERO;
        end else if (carry_clr) begin
            cin_one <= SD_ZERO;
            cin_two <= SD_ZERO;
        end else if (en_adder) begin
            cin_one <= cout_one;
            cin_two <= cout_two;
        end
    end

    logic signed [5:0] v_val;
    logic signed [5:0] r_val;
    logic signed [2:0] p_val;
    logic        [5:0] r_abs;
    logic     [MW-1:0] r_mag;

    // M-block: R = V - 8*p, saturated to +/-7 with a canonical one-sided result.
    always_comb begin
        w_upper_plus  = '0;
        w_upper_minus = '0;
        m_ovf         = 1'b0;
        p_val         = sd_val(p);
        v_val         = $signed({2'b00, v_plus}) - $signed({2'b00, v_minus});
        r_val         = v_val - $signed({p_val, 3'b000});
        r_abs         = r_val[5] ? 6'(-r_val) : 6'(r_val);
        if (r_abs > 6'd7) begin
            r_mag = 3'b111;
            m_ovf = 1'b1;
        end else begin
            r_mag = r_abs[MW-1:0];
        end
        if (r_val[5])
            w_upper_minus = r_mag;
        else
            w_upper_plus  = r_mag;
    end

endmodule

// File: tb/tb_sd_adder_slice.sv
// Directed and randomized-invariant checks for sd_adder_slice.
module tb_sd_adder_slice;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_adder;
    logic       carry_clr;
    logic [3:0] x_plus, x_minus, y_plus, y_minus;
    logic [3:0] residue_plus, residue_minus;
    logic [3:0] z_plus, z_minus, tmp_plus, tmp_minus;
    logic [1:0] cout_one, cout_two, cin_one, cin_two;
    logic [3:0] v_plus, v_minus;
    logic [1:0] p;
    logic [2:0] w_upper_plus, w_upper_minus;
    logic       m_ovf;

    int total = 0;
    int bad   = 0;

    sd_adder_slice dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_adder      (en_adder),
        .carry_clr     (carry_clr),
        .x_plus        (x_plus),
        .x_minus       (x_minus),
        .y_plus        (y_plus),
        .y_minus       (y_minus),
        .residue_plus  (residue_plus),
        .residue_minus (residue_minus),
        .z_plus        (z_plus),
        .z_minus       (z_minus),
        .tmp_plus      (tmp_plus),
        .tmp_minus     (tmp_minus),
        .cout_one      (cout_one),
        .cout_two      (cout_two),
        .cin_one       (cin_one),
        .cin_two       (cin_two),
        .v_plus        (v_plus),
        .v_minus       (v_minus),
        .p             (p),
        .w_upper_plus  (w_upper_plus),
        .w_upper_minus (w_upper_minus),
        .m_ovf         (m_ovf)
    );

    always #5 clk = ~clk;

    function automatic int dig(input logic [1:0] d);
        if (d == 2'b10) return 1;
        if (d == 2'b01) return -1;
        return 0;
    endfunction

    function automatic int vec(input logic [3:0] pl, input logic [3:0] mi);
        int acc = 0;
        for (int i = 0; i < 4; i++)
            acc += (int'(pl[i]) - int'(mi[i])) << i;
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        x_plus = '0; x_minus = '0; y_plus = '0; y_minus = '0;
        residue_plus = '0; residue_minus = '0;
        v_plus = '0; v_minus = '0; p = 2'b00;
        en_adder = 1'b0; carry_clr = 1'b0;
    endtask

    task automatic test_reset();
        zero_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({cin_one, cin_two} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_cin: got %b/%b want 00/00", cin_one, cin_two);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if ({z_plus, z_minus, tmp_plus, tmp_minus, cout_one, cout_two} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: z=%b/%b tmp=%b/%b cout=%b/%b want all zero",
                     z_plus, z_minus, tmp_plus, tmp_minus, cout_one, cout_two);
        end
    endtask

    task automatic test_carry_gen();
        x_plus = 4'b1111;
        y_plus = 4'b0001;
        #1;
        total++;
        if ({z_plus, z_minus, cout_one} !== {4'b0000, 4'b0000, 2'b10}) begin
            bad++;
            $display("FAIL carry_gen_z: z=%b/%b cout_one=%b want 0000/0000 10", z_plus, z_minus, cout_one);
        end
        total++;
        if ({tmp_plus, tmp_minus, cout_two} !== 10'b0) begin
            bad++;
            $display("FAIL carry_gen_tmp: tmp=%b/%b cout_two=%b want 0000/0000 00", tmp_plus, tmp_minus, cout_two);
        end
        en_adder = 1'b1;
        tick();
        en_adder = 1'b0;
        total++;
        if ({cin_one, cin_two} !== 4'b1000) begin
            bad++;
            $display("FAIL carry_gen_cin: got %b/%b want 10/00", cin_one, cin_two);
        end
        // cin_one=+1 now: z = +1 at digit 0, stage 2 rewrites +1 as 2-1.
        total++;
        if ({z_plus, z_minus, cout_one} !== {4'b0001, 4'b0000, 2'b10}) begin
            bad++;
            $display("FAIL carry_in_z: z=%b/%b cout_one=%b want 0001/0000 10", z_plus, z_minus, cout_one);
        end
        total++;
        if ({tmp_plus, tmp_minus, cout_two} !== {4'b0010, 4'b0001, 2'b00}) begin
            bad++;
            $display("FAIL carry_in_tmp: tmp=%b/%b cout_two=%b want 0010/0001 00", tmp_plus, tmp_minus, cout_two);
        end
    endtask

    task automatic test_hold_clear();
        en_adder = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({cin_one, cin_two} !== 4'b1000) begin
                bad++;
                $display("FAIL hold_%0d: got %b/%b want 10/00", k, cin_one, cin_two);
            end
        end
        carry_clr = 1'b1;
        en_adder  = 1'b1;
        tick();
        carry_clr = 1'b0;
        en_adder  = 1'b0;
        total++;
        if ({cin_one, cin_two} !== 4'b0000) begin
            bad++;
            $display("FAIL clear_wins: got %b/%b want 00/00", cin_one, cin_two);
        end
    endtask

    task automatic test_async_reset();
        en_adder = 1'b1;
        tick();
        en_adder = 1'b0;
        total++;
        if (cin_one !== 2'b10) begin
            bad++;
            $display("FAIL async_pre: cin_one=%b want 10", cin_one);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({cin_one, cin_two, z_plus, z_minus} !== 12'h000) begin
            bad++;
            $display("FAIL async_reset: cin=%b/%b z=%b/%b want 00/00 0000/0000",
                     cin_one, cin_two, z_plus, z_minus);
        end
        #2;
        rst_n = 1'b1;
        zero_inputs();
        tick();
    endtask

    task automatic test_invariant();
        logic [1:0] exp_c1, exp_c2;
        int lhs, rhs;
        int errs_inv = 0;
        exp_c1 = 2'b00;
        exp_c2 = 2'b00;
        for (int n = 0; n < 2000; n++) begin
            x_plus  = 4'($urandom); x_minus  = 4'($urandom);
            y_plus  = 4'($urandom); y_minus  = 4'($urandom);
            residue_plus = 4'($urandom); residue_minus = 4'($urandom);
            en_adder  = 1'($urandom);
            carry_clr = ($urandom_range(0, 15) == 0);
            #1;
            total++;
            if ({cin_one, cin_two} !== {exp_c1, exp_c2}) begin
                bad++;
                if (errs_inv++ < 10)
                    $display("FAIL inv_cin[%0d]: got %b/%b want %b/%b", n, cin_one, cin_two, exp_c1, exp_c2);
            end
            lhs = vec(z_plus, z_minus) + 16 * dig(cout_one);
            rhs = vec(x_plus, x_minus) + vec(y_plus, y_minus) + dig(exp_c1);
            total++;
            if (lhs !== rhs) begin
                bad++;
                if (errs_inv++ < 10)
                    $display("FAIL inv_stage1[%0d]: got %0d want %0d", n, lhs, rhs);
            end
            lhs = vec(tmp_plus, tmp_minus) + 16 * dig(cout_two);
            rhs = vec(z_plus, z_minus) + vec(residue_plus, residue_minus) + dig(exp_c2);
            total++;
            if (lhs !== rhs) begin
                bad++;
                if (errs_inv++ < 10)
                    $display("FAIL inv_stage2[%0d]: got %0d want %0d", n, lhs, rhs);
            end
            total++;
            if (((z_plus & z_minus) | (tmp_plus & tmp_minus)) !== 4'b0000 ||
                cout_one === 2'b11 || cout_two === 2'b11) begin
                bad++;
                if (errs_inv++ < 10)
                    $display("FAIL inv_no11[%0d]: z=%b/%b tmp=%b/%b cout=%b/%b want no 11 digit",
                             n, z_plus, z_minus, tmp_plus, tmp_minus, cout_one, cout_two);
            end
            if (carry_clr) begin
                exp_c1 = 2'b00;
                exp_c2 = 2'b00;
            end else if (en_adder) begin
                exp_c1 = cout_one;
                exp_c2 = cout_two;
            end
            tick();
        end
        zero_inputs();
    endtask

    task automatic test_mblock();
        logic [3:0] vp [7];
        logic [3:0] vm [7];
        logic [1:0] pp [7];
        logic [6:0] exp_out [7];
        vp = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0111, 4'b1000, 4'b1111};
        vm = '{4'b0000, 4'b0000, 4'b0011, 4'b1111, 4'b0000, 4'b0000, 4'b1111};
        pp = '{2'b10,   2'b01,   2'b00,   2'b10,   2'b00,   2'b00,   2'b11};
        // {w_upper_plus, w_upper_minus, m_ovf}
        exp_out = '{{3'b010, 3'b000, 1'b0},   // 10-8=2
                    {3'b111, 3'b000, 1'b1},   // 10+8=18 saturates
                    {3'b000, 3'b011, 1'b0},   // -3
                    {3'b000, 3'b111, 1'b1},   // -15-8=-23 saturates
                    {3'b111, 3'b000, 1'b0},   // 7, largest unsaturated
                    {3'b111, 3'b000, 1'b1},   // 8, smallest saturated
                    {3'b000, 3'b000, 1'b0}};  // all-11 digits read as zero
        for (int k = 0; k < 7; k++) begin
            v_plus  = vp[k];
            v_minus = vm[k];
            p       = pp[k];
            #1;
            total++;
            if ({w_upper_plus, w_upper_minus, m_ovf} !== exp_out[k]) begin
                bad++;
                $display("FAIL mblock_%0d: got %b/%b ovf=%b want %b/%b ovf=%b", k,
                         w_upper_plus, w_upper_minus, m_ovf,
                         exp_out[k][6:4], exp_out[k][3:1], exp_out[k][0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_gen();
        test_hold_clear();
        test_async_reset();
        test_invariant();
        test_mblock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
